// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - CSI-2 data types, sequencer states and packet header ECC
package csi2_pkg;

  localparam logic [5:0] DT_FS    = 6'h00;
  localparam logic [5:0] DT_FE    = 6'h01;
  localparam logic [5:0] DT_RAW10 = 6'h2B;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FS      = 3'd1,
    ST_GAP     = 3'd2,
    ST_LH      = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CRC     = 3'd5,
    ST_FE      = 3'd6,
    ST_FBLANK  = 3'd7
  } csi2_state_e;

  // Entry i lists the header data bits that feed parity bit Pi.
  localparam logic [5:0][23:0] ECC_MASK = {
    24'hEFFC00, 24'hDF03F0, 24'hB8E38E, 24'h749A6D, 24'hF2555B, 24'hF12CB7
  };

  function automatic logic [7:0] csi2_ecc(input logic [23:0] d);
    logic [7:0] ecc;
    ecc = 8'h00;
    for (int i = 0; i < 6; i++) begin
      ecc[i] = ^(d & ECC_MASK[i]);
    end
    return ecc;
  endfunction

  function automatic logic [7:0] csi2_hdr_byte(input logic [7:0] di, input logic [15:0] wc,
                                               input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = di;
      2'd1:    b = wc[7:0];
      2'd2:    b = wc[15:8];
      default: b = csi2_ecc({wc, di});
    endcase
    return b;
  endfunction

endpackage

// File: rtl/csi2_frame_sequencer_if.sv
// rtl/csi2_frame_sequencer_if.sv - byte stream toward the D-PHY lane serializer
interface csi2_frame_sequencer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic       hs_req;

  modport master (output byte_data, output byte_valid, output hs_req, input byte_ready);
  modport slave  (input byte_data, input byte_valid, input hs_req, output byte_ready);
endinterface

// File: rtl/csi2_crc16.sv
// rtl/csi2_crc16.sv - byte-wide reflected CRC-16 (poly 0x8408, seed 0xFFFF)
module csi2_crc16 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = 16'hFFFF;
    end else if (en_i) begin
      crc_d = crc_q ^ {8'h00, data_i};
      for (int i = 0; i < 8; i++) begin
        crc_d = crc_d[0] ? ((crc_d >> 1) ^ 16'h8408) : (crc_d >> 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) crc_q <= 16'hFFFF;
    else         crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/csi2_frame_sequencer.sv
// rtl/csi2_frame_sequencer.sv - CSI-2 FS / RAW10 test-pattern lines / FE generator
module csi2_frame_sequencer
  import csi2_pkg::*;
#(
  parameter int unsigned LINES       = 480,
  parameter int unsigned WORD_COUNT  = 800,
  parameter int unsigned LINE_BLANK  = 16,
  parameter int unsigned FRAME_BLANK = 4096,
  parameter logic [1:0]  VC          = 2'd0
) (
  input  logic                          i2c_slave_top_ref_clk_i,
  input  logic                          i2c_slave_top_reset_i,
  input  logic                          csi2_stream_run_i,
  csi2_frame_sequencer_if.master        px,
  output logic                          frame_active_o,
  output logic [15:0]                   frame_count_o
);

  localparam int unsigned LINE_W    = $clog2(LINES + 1);
  localparam int unsigned BLANK_MAX = (LINE_BLANK > FRAME_BLANK) ? LINE_BLANK : FRAME_BLANK;
  localparam int unsigned BLANK_W   = $clog2(BLANK_MAX) + 1;

  localparam logic [15:0]         WC16      = 16'(WORD_COUNT);
  localparam logic [15:0]         COL_LAST  = 16'(WORD_COUNT - 1);
  localparam logic [LINE_W-1:0]   LINES_L   = LINE_W'(LINES);
  localparam logic [BLANK_W-1:0]  LB_LAST   = BLANK_W'(LINE_BLANK);
  localparam logic [BLANK_W-1:0]  FB_LAST   = BLANK_W'(FRAME_BLANK);

  csi2_state_e         state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [15:0]         col_q, col_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic [15:0]         frame_num_q, frame_num_d;
  logic                run_q, run_d;

  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_hs;
  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc_val;
  logic [15:0] frame_next;
  logic [5:0]  hdr_dt;
  logic [15:0] hdr_wc;

  // Frame numbers skip 0 on wrap so a zero WC never appears in FS/FE.
  assign frame_next = (frame_num_q == 16'hFFFF) ? 16'h0001 : frame_num_q + 16'h0001;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    col_d       = col_q;
    line_d      = line_q;
    blank_d     = blank_q;
    frame_num_d = frame_num_q;
    run_d       = 1'b0;
    tx_byte     = 8'h00;
    tx_valid    = 1'b0;
    tx_hs       = 1'b0;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    hdr_dt      = DT_RAW10;
    hdr_wc      = WC16;

    if (state_q == ST_FS) begin
      hdr_dt = DT_FS;
      hdr_wc = frame_num_q;
    end else if (state_q == ST_FE) begin
      hdr_dt = DT_FE;
      hdr_wc = frame_num_q;
    end

    case (state_q)
      ST_IDLE: begin
        // run is registered once before committing to a frame.
        run_d = csi2_stream_run_i;
        if (run_q) begin
          state_d     = ST_FS;
          frame_num_d = frame_next;
          line_d      = '0;
          byte_cnt_d  = 2'd0;
        end
      end
      ST_FS, ST_LH, ST_FE: begin
        tx_valid = 1'b1;
        tx_hs    = 1'b1;
        tx_byte  = csi2_hdr_byte({VC, hdr_dt}, hdr_wc, byte_cnt_q);
        if (px.byte_ready) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            blank_d = '0;
            col_d   = '0;
            if (state_q == ST_FS) begin
              state_d = ST_GAP;
            end else if (state_q == ST_LH) begin
              state_d  = ST_PAYLOAD;
              crc_init = 1'b1;
            end else begin
              state_d = ST_FBLANK;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_hs    = 1'b1;
        tx_byte  = 8'(line_q) ^ col_q[7:0];
        if (px.byte_ready) begin
          crc_en = 1'b1;
          col_d  = col_q + 16'd1;
          if (col_q == COL_LAST) begin
            state_d    = ST_CRC;
            byte_cnt_d = 2'd0;
          end
        end
      end
      ST_CRC: begin
        tx_valid = 1'b1;
        tx_hs    = 1'b1;
        tx_byte  = byte_cnt_q[0] ? crc_val[15:8] : crc_val[7:0];
        if (px.byte_ready) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q[0]) begin
            state_d    = ST_GAP;
            blank_d    = '0;
            byte_cnt_d = 2'd0;
            line_d     = line_q + LINE_W'(1);
          end
        end
      end
      ST_GAP: begin
        blank_d = blank_q + BLANK_W'(1);
        if (blank_q == LB_LAST) begin
          blank_d    = '0;
          byte_cnt_d = 2'd0;
          state_d    = (line_q == LINES_L) ? ST_FE : ST_LH;
        end
      end
      ST_FBLANK: begin
        blank_d = blank_q + BLANK_W'(1);
        if (blank_q == FB_LAST) begin
          blank_d = '0;
          if (csi2_stream_run_i) begin
            state_d     = ST_FS;
            frame_num_d = frame_next;
            line_d      = '0;
            byte_cnt_d  = 2'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i2c_slave_top_ref_clk_i or negedge i2c_slave_top_reset_i) begin
    if (!i2c_slave_top_reset_i) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      col_q       <= '0;
      line_q      <= '0;
      blank_q     <= '0;
      frame_num_q <= '0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      col_q       <= col_d;
      line_q      <= line_d;
      blank_q     <= blank_d;
      frame_num_q <= frame_num_d;
      run_q       <= run_d;
    end
  end

  csi2_crc16 u_crc (
    .clk_i  (i2c_slave_top_ref_clk_i),
    .rst_ni (i2c_slave_top_reset_i),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (tx_byte),
    .crc_o  (crc_val)
  );

  assign px.byte_data    = tx_byte;
  assign px.byte_valid   = tx_valid;
  assign px.hs_req       = tx_hs;
  assign frame_active_o  = (state_q != ST_IDLE) && (state_q != ST_FBLANK);
  assign frame_count_o   = frame_num_q;

endmodule

// File: tb/tb_csi2_frame_sequencer.sv
// tb/tb_csi2_frame_sequencer.sv - self-checking bench for csi2_frame_sequencer
`define CHK(TAG, OBS, EXP) \
  begin \
    checks++; \
    assert ((OBS) === (EXP)) else begin \
      errors++; \
      $error("FAIL %s: observed=%0h expected=%0h", TAG, OBS, EXP); \
    end \
  end

module tb_csi2_frame_sequencer;

  localparam int         LINES       = 2;
  localparam int         WORD_COUNT  = 4;
  localparam int         LINE_BLANK  = 3;
  localparam int         FRAME_BLANK = 5;
  localparam logic [1:0] VC_TB       = 2'd0;
  localparam int         FRAME_BYTES = 8 + LINES * (WORD_COUNT + 6);
  localparam int         BUDGET      = 3000;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        frame_active;
  logic [15:0] frame_count;

  csi2_frame_sequencer_if bus ();

  csi2_frame_sequencer #(
    .LINES       (LINES),
    .WORD_COUNT  (WORD_COUNT),
    .LINE_BLANK  (LINE_BLANK),
    .FRAME_BLANK (FRAME_BLANK),
    .VC          (VC_TB)
  ) dut (
    .i2c_slave_top_ref_clk_i (clk),
    .i2c_slave_top_reset_i   (rst_n),
    .csi2_stream_run_i       (run),
    .px                      (bus.master),
    .frame_active_o          (frame_active),
    .frame_count_o           (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int span;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int hi_runs[$];
  int lo_runs[$];

  // Syndrome column of each header data bit (which parity bits it flips).
  logic [7:0] ecc_tab [0:23] = '{
    8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
    8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
    8'h31, 8'h32, 8'h34, 8'h38, 8'h1F, 8'h2F, 8'h37, 8'h3B
  };

  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [7:0] e;
    e = 8'h00;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ ecc_tab[i];
    return e;
  endfunction

  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'h8408;
    end
    return c;
  endfunction

  function automatic void push_hdr(input logic [5:0] dt, input logic [15:0] wc);
    logic [7:0] di;
    di = {VC_TB, dt};
    exp_q.push_back(di);
    exp_q.push_back(wc[7:0]);
    exp_q.push_back(wc[15:8]);
    exp_q.push_back(ref_ecc({wc, di}));
  endfunction

  function automatic void build_frame(input logic [15:0] fn);
    logic [15:0] crc;
    logic [7:0]  b;
    exp_q.delete();
    push_hdr(6'h00, fn);
    for (int ln = 0; ln < LINES; ln++) begin
      push_hdr(6'h2B, 16'(WORD_COUNT));
      crc = 16'hFFFF;
      for (int c = 0; c < WORD_COUNT; c++) begin
        b = 8'(ln) ^ 8'(c);
        exp_q.push_back(b);
        crc = ref_crc(crc, b);
      end
      exp_q.push_back(crc[7:0]);
      exp_q.push_back(crc[15:8]);
    end
    push_hdr(6'h01, fn);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int ready_pct, input int drop_at, input int stop_at);
    int nacc, hi_run, lo_run, target;
    bit started, pstall, rdy;
    logic v, h;
    logic [7:0] b, pb;
    got_q.delete(); hi_runs.delete(); lo_runs.delete();
    span = 0; nacc = 0; hi_run = 0; lo_run = 0;
    started = 1'b0; pstall = 1'b0; pb = 8'h00;
    target = (stop_at > 0) ? stop_at : FRAME_BYTES;
    for (int cyc = 0; cyc < BUDGET && nacc < target; cyc++) begin
      v = bus.byte_valid; b = bus.byte_data; h = bus.hs_req;
      if (pstall) begin
        `CHK("stall_valid", v, 1'b1)
        `CHK("stall_byte", b, pb)
      end
      if (h) started = 1'b1;
      if (started) begin
        span++;
        if (h) begin
          if (lo_run > 0) lo_runs.push_back(lo_run);
          lo_run = 0; hi_run++;
        end else begin
          if (hi_run > 0) hi_runs.push_back(hi_run);
          hi_run = 0; lo_run++;
        end
      end
      rdy = (int'($urandom_range(99)) < ready_pct);
      bus.byte_ready = rdy;
      @(posedge clk);
      if (v && rdy) begin
        got_q.push_back(b);
        nacc++;
        if (nacc == drop_at) run = 1'b0;
      end
      pstall = v && !rdy;
      pb = b;
      #1;
    end
    if (hi_run > 0) hi_runs.push_back(hi_run);
    `CHK("capture_done", nacc, target)
    bus.byte_ready = 1'b1;
  endtask

  task automatic check_bytes(input string tag);
    `CHK({tag, "_len"}, got_q.size(), exp_q.size())
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      `CHK($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i])
    end
  endtask

  task automatic check_runs(input string tag, input bit with_hi);
    `CHK({tag, "_gaps"}, lo_runs.size(), LINES + 1)
    foreach (lo_runs[i]) `CHK($sformatf("%s_gap%0d", tag, i), lo_runs[i], LINE_BLANK + 1)
    if (with_hi) begin
      `CHK({tag, "_pkts"}, hi_runs.size(), LINES + 2)
      foreach (hi_runs[i]) begin
        `CHK($sformatf("%s_pkt%0d", tag, i), hi_runs[i],
             (i == 0 || i == LINES + 1) ? 4 : WORD_COUNT + 6)
      end
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.byte_valid && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n, bad;
    rst_n = 1'b0; run = 1'b1; bus.byte_ready = 1'b1;
    #1;
    `CHK("rst_byte", bus.byte_data, 8'h00)
    `CHK("rst_valid", bus.byte_valid, 1'b0)
    `CHK("rst_hs", bus.hs_req, 1'b0)
    `CHK("rst_active", frame_active, 1'b0)
    `CHK("rst_count", frame_count, 16'h0000)
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tick();
    `CHK("start_decision", bus.byte_valid, 1'b0)
    tick();
    `CHK("start_valid", bus.byte_valid, 1'b1)
    `CHK("start_count", frame_count, 16'h0001)
    `CHK("start_active", frame_active, 1'b1)

    build_frame(16'h0001);
    capture(100, 0, 0);
    check_bytes("f1");
    check_runs("f1", 1'b1);
    `CHK("f1_cycles", span, 8 + LINES * (WORD_COUNT + 6) + (LINES + 1) * (LINE_BLANK + 1))
    if (got_q.size() == FRAME_BYTES) begin
      `CHK("f1_fs_const", {got_q[0], got_q[1], got_q[2], got_q[3]}, 32'h0001001A)
      `CHK("f1_line1_const", {got_q[18], got_q[19], got_q[20], got_q[21]}, 32'h01000302)
      `CHK("f1_fe_const", {got_q[24], got_q[25], got_q[26], got_q[27]}, 32'h0101001D)
    end
    `CHK("f1_active_after", frame_active, 1'b0)

    wait_valid(n);
    `CHK("fblank_len1", n, FRAME_BLANK + 1)
    `CHK("f2_count", frame_count, 16'h0002)
    build_frame(16'h0002);
    capture(50, 0, 0);
    check_bytes("f2");
    check_runs("f2", 1'b0);

    wait_valid(n);
    `CHK("fblank_len2", n, FRAME_BLANK + 1)
    build_frame(16'h0003);
    capture(100, 10, 0);
    check_bytes("f3");
    check_runs("f3", 1'b1);
    bad = 0;
    for (int i = 0; i < 8 * (FRAME_BLANK + 1); i++) begin
      if (bus.hs_req !== 1'b0 || bus.byte_valid !== 1'b0 || frame_active !== 1'b0) bad++;
      tick();
    end
    `CHK("stopped_quiet", bad, 0)
    `CHK("stopped_count", frame_count, 16'h0003)

    force dut.frame_num_q = 16'hFFFF;
    repeat (2) tick();
    release dut.frame_num_q;
    tick();
    `CHK("forced_count", frame_count, 16'hFFFF)
    run = 1'b1;
    tick();
    tick();
    `CHK("wrap_valid", bus.byte_valid, 1'b1)
    `CHK("wrap_count", frame_count, 16'h0001)
    build_frame(16'h0001);
    capture(100, 0, 11);
    exp_q = exp_q[0:10];
    check_bytes("wrap");

    #2;
    rst_n = 1'b0;
    #1;
    `CHK("midrst_byte", bus.byte_data, 8'h00)
    `CHK("midrst_valid", bus.byte_valid, 1'b0)
    `CHK("midrst_hs", bus.hs_req, 1'b0)
    `CHK("midrst_active", frame_active, 1'b0)
    `CHK("midrst_count", frame_count, 16'h0000)
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    `CHK("rerun_valid", bus.byte_valid, 1'b1)
    `CHK("rerun_count", frame_count, 16'h0001)
    build_frame(16'h0001);
    capture(50, 0, 0);
    check_bytes("rerun");
    check_runs("rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
